// File: rtl/modaddsub_sched.sv
// rtl/modaddsub_sched.sv - round-robin shared GF(2^255-19) add/sub pipeline with tagged responses
// Optional: define MODADDSUB_SCHED_PRIO0_EN to give requester 0 absolute priority.
module modaddsub_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_op,
    input  logic [NREQ*255-1:0] req_a,
    input  logic [NREQ*255-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [254:0]        rsp_z,
    output logic                busy
);

`ifdef MODADDSUB_SCHED_PRIO0_EN
    localparam bit PRIO0_EN = 1'b1;
`else
    localparam bit PRIO0_EN = 1'b0;
`endif

    localparam logic [254:0] P = {{247{1'b1}}, 8'hED};

    logic           s1_v_q, s1_v_d;
    logic           s1_op_q, s1_op_d;
    logic [254:0]   s1_a_q, s1_a_d;
    logic [254:0]   s1_b_q, s1_b_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           s2_v_q, s2_v_d;
    logic [254:0]   s2_z_q, s2_z_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           adv1, adv2;
    logic           gnt_any, gnt_prio;
    logic [IDW-1:0] gnt_id;

    logic [255:0]   diff, sum;
    logic [256:0]   sum_m_p;
    logic [254:0]   z_sub, z_add, z;

    always_comb begin : arb
        int             idx;
        logic [IDW-1:0] idx_l;
        idx       = 0;
        idx_l     = '0;
        gnt_any   = 1'b0;
        gnt_prio  = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        adv2      = ~s2_v_q | rsp_ready;
        adv1      = ~s1_v_q | adv2;
        if (PRIO0_EN && req_valid[0]) begin
            gnt_any  = 1'b1;
            gnt_prio = 1'b1;
        end
        // First requesting index at or after ptr; requester 0 is excluded when it has priority.
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(ptr_q) + k) % NREQ;
            idx_l = IDW'(idx);
            if (!gnt_any && req_valid[idx_l] && !(PRIO0_EN && idx == 0)) begin
                gnt_any = 1'b1;
                gnt_id  = idx_l;
            end
        end
        if (gnt_any && adv1 && !rst) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin : datapath
        diff    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        z_sub   = diff[255] ? (diff[254:0] + P) : diff[254:0];
        sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        sum_m_p = {1'b0, sum} - {2'b00, P};
        z_add   = sum_m_p[256] ? sum[254:0] : sum_m_p[254:0];
        z       = s1_op_q ? z_add : z_sub;
    end

    always_comb begin : next_state
        s1_v_d  = s1_v_q;
        s1_op_d = s1_op_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_id_d = s1_id_q;
        s2_v_d  = s2_v_q;
        s2_z_d  = s2_z_q;
        s2_id_d = s2_id_q;
        ptr_d   = ptr_q;
        if (adv1) begin
            s1_v_d = gnt_any;
            if (gnt_any) begin
                s1_op_d = req_op[gnt_id];
                s1_a_d  = req_a[255*gnt_id +: 255];
                s1_b_d  = req_b[255*gnt_id +: 255];
                s1_id_d = gnt_id;
                if (!gnt_prio) begin
                    ptr_d = IDW'((int'(gnt_id) + 1) % NREQ);
                end
            end
        end
        // S2 only reloads when its result has been taken, keeping rsp_* stable under backpressure.
        if (adv2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_z_d  = z;
                s2_id_d = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s1_op_q <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
            s2_z_q  <= '0;
            s2_id_q <= '0;
            ptr_q   <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_op_q <= s1_op_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s1_id_q <= s1_id_d;
            s2_v_q  <= s2_v_d;
            s2_z_q  <= s2_z_d;
            s2_id_q <= s2_id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rsp_valid = s2_v_q;
    assign rsp_z     = s2_z_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_modaddsub_sched.sv
// tb/tb_modaddsub_sched.sv - randomized and directed bench for modaddsub_sched with a queue-based reference model
module tb_modaddsub_sched;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_ready;
    logic [3:0]    req_op = '0;
    logic [1019:0] req_a = '0;
    logic [1019:0] req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_id;
    logic [254:0]  rsp_z;
    logic          busy;

    modaddsub_sched #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   id;
        logic [254:0] z;
        int           age;
    } ent_t;

    ent_t         mq[$];
    int           mptr = 0;
    int           total = 0;
    int           bad = 0;
    logic [257:0] pw;
    logic [254:0] pc;

    logic [3:0]   obs_ready, exp_ready;
    logic         obs_rv, exp_rv, obs_busy, rsp_fire;
    logic [1:0]   obs_id, exp_id;
    logic [254:0] obs_z, exp_z;

    function automatic logic [254:0] ref_z(input logic op, input logic [254:0] a, input logic [254:0] b);
        logic [257:0] r;
        if (op) r = ({3'b0, a} + {3'b0, b}) % pw;
        else    r = ({3'b0, a} + pw - {3'b0, b}) % pw;
        return r[254:0];
    endfunction

    function automatic logic [254:0] rnd255();
        logic [255:0] r;
        int           sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return pc - 255'd1;
        if (sel == 2) return 255'd1;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        if (r[254:0] >= pc) return r[254:0] - pc;
        return r[254:0];
    endfunction

    function automatic logic [3:0] model_grant();
        int i;
        if (rst) return 4'b0;
        if (!(mq.size() < 2 || rsp_ready)) return 4'b0;
`ifdef MODADDSUB_SCHED_PRIO0_EN
        if (req_valid[0]) return 4'b0001;
`endif
        for (int k = 0; k < 4; k++) begin
            i = (mptr + k) % 4;
`ifdef MODADDSUB_SCHED_PRIO0_EN
            if (i == 0) continue;
`endif
            if (req_valid[i]) return 4'(1 << i);
        end
        return 4'b0;
    endfunction

    task automatic set_req(input int i, input logic op, input logic [254:0] a, input logic [254:0] b);
        req_op[i]          = op;
        req_a[255*i +: 255] = a;
        req_b[255*i +: 255] = b;
    endtask

    // One clock: sample DUT mid-cycle, predict, then advance the model over the edge.
    task automatic tick();
        int   gi;
        ent_t e;
        @(negedge clk);
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_id    = rsp_id;
        obs_z     = rsp_z;
        obs_busy  = busy;
        exp_ready = model_grant();
        exp_rv    = (mq.size() > 0) && (mq[0].age >= 1);
        rsp_fire  = obs_rv && rsp_ready;
        exp_id    = 'x;
        exp_z     = 'x;
        if (mq.size() > 0) begin
            exp_id = mq[0].id;
            exp_z  = mq[0].z;
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mptr = 0;
        end else begin
            if (rsp_fire && mq.size() > 0) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age++;
            if (exp_ready != 4'b0) begin
                gi = 0;
                for (int i = 0; i < 4; i++) if (exp_ready[i]) gi = i;
                e.id  = 2'(gi);
                e.z   = ref_z(req_op[gi], req_a[255*gi +: 255], req_b[255*gi +: 255]);
                e.age = 0;
                mq.push_back(e);
`ifdef MODADDSUB_SCHED_PRIO0_EN
                if (gi != 0) mptr = (gi + 1) % 4;
`else
                mptr = (gi + 1) % 4;
`endif
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8 && (mq.size() > 0 || busy); c++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        tick();
        total++; if (obs_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", obs_ready); end
        rst = 1'b0;
        req_valid = '0;
        tick();
        total++; if (obs_rv !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", obs_rv); end
        total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", obs_busy); end
        total++; if (obs_id !== 2'd0 || obs_z !== 255'd0) begin bad++; $display("FAIL reset_rsp_data got id=%0d z=%h exp 0/0", obs_id, obs_z); end
    endtask

    task automatic test_sub();
        rsp_ready = 1'b1;
        set_req(2, 1'b0, 255'd0, 255'd1);
        req_valid = 4'b0100;
        tick();
        total++; if (obs_ready !== 4'b0100) begin bad++; $display("FAIL sub_grant got=%b exp=0100", obs_ready); end
        req_valid = '0;
        tick();
        total++; if (obs_rv !== 1'b0 || obs_busy !== 1'b1) begin bad++; $display("FAIL sub_lat1 got rv=%b busy=%b exp 0/1", obs_rv, obs_busy); end
        tick();
        total++; if (obs_rv !== 1'b1 || obs_id !== 2'd2 || obs_z !== pc - 255'd1) begin
            bad++; $display("FAIL sub_result got rv=%b id=%0d z=%h exp 1/2/%h", obs_rv, obs_id, obs_z, pc - 255'd1);
        end
        tick();
    endtask

    task automatic test_add_back_to_back();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, pc - 255'd1, 255'd2);
        req_valid = 4'b0010;
        tick();
        total++; if (obs_ready !== 4'b0010) begin bad++; $display("FAIL add_grant0 got=%b exp=0010", obs_ready); end
        set_req(1, 1'b1, 255'd5, 255'd7);
        tick();
        total++; if (obs_ready !== 4'b0010) begin bad++; $display("FAIL add_grant1 got=%b exp=0010", obs_ready); end
        req_valid = '0;
        tick();
        total++; if (obs_rv !== 1'b1 || obs_id !== 2'd1 || obs_z !== 255'd1) begin bad++; $display("FAIL add_wrap got rv=%b id=%0d z=%h exp 1/1/1", obs_rv, obs_id, obs_z); end
        tick();
        total++; if (obs_rv !== 1'b1 || obs_id !== 2'd1 || obs_z !== 255'd12) begin bad++; $display("FAIL add_small got rv=%b id=%0d z=%h exp 1/1/c", obs_rv, obs_id, obs_z); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] eg[5];
        logic [1:0] ei[5];
`ifdef MODADDSUB_SCHED_PRIO0_EN
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        ei = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ei = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'($urandom_range(0, 1)), rnd255(), rnd255());
        req_valid = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) req_valid = '0;
            tick();
            if (c < 5) begin
                total++; if (obs_ready !== eg[c]) begin bad++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, obs_ready, eg[c]); end
            end
            if (c >= 2) begin
                total++; if (obs_rv !== 1'b1 || obs_id !== ei[c-2] || obs_z !== exp_z) begin
                    bad++; $display("FAIL rr_rsp c=%0d got rv=%b id=%0d exp id=%0d", c, obs_rv, obs_id, ei[c-2]);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int           grants;
        logic [254:0] hz;
        logic [1:0]   hid;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'($urandom_range(0, 1)), rnd255(), rnd255());
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        grants = 0;
        hz = '0;
        hid = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            grants += $countones(obs_ready);
            if (c == 2) begin hz = obs_z; hid = obs_id; end
            if (c >= 2) begin
                total++; if (obs_rv !== 1'b1 || obs_z !== hz || obs_id !== hid || obs_z !== exp_z) begin
                    bad++; $display("FAIL stall_hold c=%0d got rv=%b id=%0d z=%h exp z=%h", c, obs_rv, obs_id, obs_z, exp_z);
                end
            end
        end
        total++; if (grants !== 2) begin bad++; $display("FAIL stall_grants got=%0d exp=2", grants); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (obs_ready !== exp_ready || obs_ready == 4'b0) begin bad++; $display("FAIL resume_grant c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
            total++; if (!rsp_fire || obs_id !== exp_id || obs_z !== exp_z) begin bad++; $display("FAIL resume_rsp c=%0d got rv=%b id=%0d exp id=%0d", c, obs_rv, obs_id, exp_id); end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++; if (obs_ready !== 4'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0000", obs_ready); end
        rst = 1'b0;
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 255'd3, 255'd4);
        req_valid = 4'b0010;
        tick();
        total++; if (obs_rv !== 1'b0 || obs_busy !== 1'b0) begin bad++; $display("FAIL midrst_flush got rv=%b busy=%b exp 0/0", obs_rv, obs_busy); end
        total++; if (obs_ready !== 4'b0010) begin bad++; $display("FAIL midrst_grant got=%b exp=0010", obs_ready); end
        req_valid = '0;
        tick();
        tick();
        total++; if (obs_rv !== 1'b1 || obs_id !== 2'd1 || obs_z !== 255'd7) begin bad++; $display("FAIL midrst_rsp got rv=%b id=%0d z=%h exp 1/1/7", obs_rv, obs_id, obs_z); end
        tick();
        total++; if (obs_rv !== 1'b0) begin bad++; $display("FAIL midrst_stale got rv=%b exp=0", obs_rv); end
    endtask

    task automatic test_prio_pair();
        logic [3:0] eg[4];
`ifdef MODADDSUB_SCHED_PRIO0_EN
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        eg = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (obs_ready !== eg[c]) begin bad++; $display("FAIL pair_grant c=%0d got=%b exp=%b", c, obs_ready, eg[c]); end
        end
        req_valid = 4'b1000;
        tick();
        total++; if (obs_ready !== 4'b1000) begin bad++; $display("FAIL pair_drop0 got=%b exp=1000", obs_ready); end
        drain();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) set_req(i, 1'($urandom_range(0, 1)), rnd255(), rnd255());
            tick();
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
            total++; if (obs_rv !== exp_rv) begin bad++; $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b", c, obs_rv, exp_rv); end
            if (rsp_fire) begin
                total++; if (obs_id !== exp_id || obs_z !== exp_z) begin bad++; $display("FAIL rand_rsp c=%0d got id=%0d z=%h exp id=%0d z=%h", c, obs_id, obs_z, exp_id, exp_z); end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_fire) begin
                total++; if (obs_id !== exp_id || obs_z !== exp_z) begin bad++; $display("FAIL rand_drain c=%0d got id=%0d exp id=%0d", c, obs_id, exp_id); end
            end
        end
        total++; if (mq.size() != 0 || obs_busy !== 1'b0) begin bad++; $display("FAIL rand_empty got left=%0d busy=%b exp 0/0", mq.size(), obs_busy); end
    endtask

    initial begin
        pw = (258'd1 << 255) - 258'd19;
        pc = pw[254:0];
        test_reset();
        test_sub();
        test_add_back_to_back();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_prio_pair();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
